// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed, active-low 4-digit 7-segment bus and
// decodes each stable digit pattern back into a hex nibble, with per-digit
// error/blank flags and frame-completion tracking.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  dig_n,
  output logic [15:0] value,
  output logic [3:0]  err,
  output logic [3:0]  blank,
  output logic [3:0]  seen,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        frame_done
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

  // Raw (active-low) {dig_n, seg_n} samples; all ones means nothing driven.
  logic [10:0] s1, s2;
  logic [10:0] cur;
  logic [7:0]  cnt;
  logic        armed;

  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        stable_hit;
  logic        accept;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        is_blank;
  logic        is_err;
  logic [3:0]  seen_next;

  // Two-flop synchronizer on all segment and digit-enable lines.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes s1->s2 a real chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= {dig_n, seg_n};
      s2 <= s1;
    end
  end

  // Stability tracker: restart the run count whenever the sample changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur   <= '1;
      cnt   <= '0;
      armed <= 1'b0;
    end else if (s2 != cur) begin
      cur   <= s2;
      cnt   <= 8'd1;
      armed <= 1'b1;
    end else begin
      if (cnt < CNT_MAX) cnt <= cnt + 8'd1;
      // Only one accept attempt per stable run, even if dig is not one-hot.
      if (stable_hit) armed <= 1'b0;
    end
  end

  // Accept qualification and glyph decode of the held pattern.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    seg        = ~cur[6:0];
    dig        = ~cur[10:7];
    stable_hit = (s2 == cur) && (cnt == CNT_HIT) && armed;
    accept     = stable_hit && $onehot(dig);
    idx        = 2'd0;
    nib        = 4'h0;
    is_blank   = 1'b0;
    is_err     = 1'b0;

    case (dig)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase

    case (seg)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h7B: nib = 4'hE;
      7'h71: nib = 4'hF;
      7'h00: is_blank = 1'b1;
      default: is_err = 1'b1;
    endcase

    seen_next = seen | (4'b0001 << idx);
  end

  // Output registers: update the accepted digit and track frame completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value      <= '0;
      err        <= '0;
      blank      <= '0;
      seen       <= '0;
      upd        <= 1'b0;
      upd_idx    <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      upd        <= accept;
      frame_done <= 1'b0;
      if (accept) begin
        upd_idx    <= idx;
        err[idx]   <= is_err;
        blank[idx] <= is_blank;
        // An illegal glyph leaves the previously decoded nibble in place.
        if (!is_err) value[idx*4 +: 4] <= nib;
        if (seen_next == 4'hF) begin
          seen       <= 4'h0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side counterpart of the board's hex-to-seven-segment encoder. It samples an externally driven, time-multiplexed 4-digit active-low 7-segment bus (segments plus digit enables) on GPIO. It waits for each digit pattern to be stable, decodes it back to a 4-bit hex nibble, and presents a 16-bit word with per-digit error and blank flags. It sits between the GPIO input pins and the HSM interface logic, so the logic can read the value an attached device is displaying.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a digit is accepted. Legal range 2..255.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `seg_n` input 7: segment lines, active-low and asynchronous to `clk`.
  - Bit mapping: 0 = top, 1 = upper-right, 2 = lower-right, 3 = bottom, 4 = lower-left, 5 = upper-left, 6 = middle.
- `dig_n` input 4: digit enables, active-low and asynchronous. Bit i selects digit i; digit 0 is the least significant.
- `value` output 16: decoded nibbles. `value[4i+3:4i]` holds digit i.
- `err` output 4: digit i's last accepted pattern was not a legal glyph.
- `blank` output 4: digit i's last accepted pattern had all segments off.
- `seen` output 4: digit i has been accepted since the last frame completion or reset.
- `upd` output 1: one-cycle pulse; a digit was accepted this cycle.
- `upd_idx` output 2: index of the digit accepted. Valid while `upd` is high.
- `frame_done` output 1: one-cycle pulse; all four digits have been accepted.

## Operation
- **Input synchronizer:** two-flop synchronizer on all 11 input bits. Later logic uses the second stage `s2`, inverted to active-high `seg[6:0]` and `dig[3:0]`.
- **Stability tracker:** holds `cur` (11 bits), `cnt` (8 bits) and `armed`. At each edge:
  - If `s2 != cur`: load `cur <= s2`, set `cnt <= 1`, set `armed <= 1`.
  - Otherwise, if `cnt < STABLE_CYCLES`: increment `cnt`. `cnt` saturates at `STABLE_CYCLES`.
- **Accept condition:** at an edge where `s2 == cur`, `cnt == STABLE_CYCLES-1` and `armed == 1`, clear `armed`, then evaluate `dig`:
  - Exactly one bit of `dig` set, say bit i: accept digit i. Exactly one accept per stable run.
  - `dig` zero or multi-hot: no accept; all outputs hold.
- **Decode, active-high glyph to nibble:**
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7.
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 7B→E, 71→F.
  - 00 → blank.
  - Any other pattern → error.
- **On accepting digit i:**
  - Legal glyph: write the nibble to digit i, clear `err[i]`, clear `blank[i]`.
  - Blank: write nibble 0, set `blank[i]`, clear `err[i]`.
  - Error: nibble i holds its old value, set `err[i]`, clear `blank[i]`.
  - In all three cases: set `seen[i]`, pulse `upd`, drive `upd_idx = i`.
- **Frame completion:** if the accept makes `seen` equal to 4'hF, pulse `frame_done` in the same cycle as `upd` and clear `seen` to 0 on that edge. In that cycle `seen` reads 0 and `frame_done` reads 1.
  - Re-accepting an already-seen digit sets nothing new and does not complete a frame.

## Timing
- **Reset (`rst_n` low at an edge):**
  - Outputs: `value` = 0, `err` = 0, `blank` = 0, `seen` = 0, `upd` = 0, `upd_idx` = 0, `frame_done` = 0.
  - Internal: synchronizer flops = all ones (inactive), `cur` = 11'h7FF, `cnt` = 0, `armed` = 0.
  - Reset mid-run discards any partial stability count. A pattern still held after reset release is accepted once, counted from the release.
- **Latency:**
  - Inputs change before edge k and are held. `s2` shows the new value after edge k+1.
  - `cur` loads at edge k+2. Accept happens at edge k+1+`STABLE_CYCLES`.
  - All outputs are registered. They change, and `upd` is high, in the cycle after that edge (edge k+5 for the default).
- **Glitches:** a change that lasts fewer than `STABLE_CYCLES` samples never accepts. Returning to a prior pattern re-arms and restarts the count.
- **Saturation:** a pattern held indefinitely produces exactly one `upd`.
- **No backpressure:** `upd` and `frame_done` are single-cycle pulses. Consecutive accepts are at least `STABLE_CYCLES` cycles apart.

## Test plan
- **Single stable digit:** `seg_n` = 7'h40 (glyph 0), `dig_n` = 4'b1110, held 20 cycles.
  - Expect one `upd` at edge k+5, `upd_idx` = 0, `value[3:0]` = 0, `err` = 0, `seen` = 4'b0001.
- **Glitch rejection:** hold `seg_n` = 7'h79 (glyph 1) on digit 2 for 3 cycles, then change it.
  - Expect no `upd`; outputs unchanged.
- **Full frame:** glyphs 1, 2, 3, 4 on digits 0..3, 8 cycles each.
  - Expect 4 `upd` pulses and `value` = 16'h4321.
  - `frame_done` pulses only with the 4th `upd`, and `seen` returns to 0.
- **Illegal and blank glyphs:** after the full frame, send active-high 7'h01 on digit 1, then 7'h00 on digit 3.
  - Expect `err[1]` = 1 with `value[7:4]` still 2.
  - Then `blank[3]` = 1 with `value[15:12]` = 0.
- **Bad enables:** stable valid segments with `dig_n` = 4'b0000, then 4'b1111, each for 10 cycles.
  - Expect no `upd` in either case.
- **Reset mid-run:** assert `rst_n` low for 1 cycle at count 2 of a stable digit-0 glyph 5 (`seg_n` = 7'h12, `dig_n` = 4'b1110), keeping the inputs held through and after reset.
  - Expect all outputs 0 after reset.
  - Expect exactly one `upd` with `value[3:0]` = 5 at edge (release+1+`STABLE_CYCLES`) = release+5 for the default.
